instr_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the instruction decoder. Holds the PC, issues

---
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle imem reads, 2-entry instruction FIFO to decode.
// Redirects flush the FIFO and drop in-flight data; misaligned targets halt.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fetch_fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tag;
    logic            inflight;
    logic [1:0]      count;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [XLEN-1:0] data_q [2];
    logic [XLEN-1:0] addr_q [2];

    logic            misaligned;
    logic            pop;
    logic            push;
    logic [2:0]      occ;

    assign misaligned  = redirect_pc[1:0] != 2'b00;
    assign instr_valid = count != 2'd0;
    assign instr       = data_q[rd_ptr];
    assign instr_pc    = addr_q[rd_ptr];
    assign imem_addr   = redirect_valid ? redirect_pc : pc;

    // A redirect wins over both the decoder pop and the pending response.
    assign pop  = instr_valid && instr_ready && !redirect_valid;
    assign push = inflight && !redirect_valid;
    assign occ  = {2'b00, inflight} + {1'b0, count} - {2'b00, pop};

    always_comb begin
        imem_req = 1'b0;
        if (redirect_valid)
            imem_req = !misaligned;
        else if (state == S_FETCH)
            imem_req = occ < 3'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            tag         <= '0;
            inflight    <= 1'b0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fetch_fault <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                state <= misaligned ? S_HALT : S_FETCH;
                if (misaligned)
                    fetch_fault <= 1'b1;
            end else if (state == S_IDLE) begin
                state <= S_FETCH;
            end

            inflight <= imem_req;
            if (imem_req) begin
                pc  <= imem_addr + XLEN'(4);
                tag <= imem_addr;
            end

            if (redirect_valid) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    data_q[wr_ptr] <= imem_rdata;
                    addr_q[wr_ptr] <= tag;
                    wr_ptr         <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(push && !pop && count == 2'd2)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model returns addr^K one cycle later,
// expected PCs are queued per scenario and popped on each decode handshake.
module tb_instr_fetch_unit;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        fetch_fault;

    logic        reset_w = 1'b1;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_rv = 1'b0;
    logic [31:0] w_rpc = '0;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_ready = 1'b1;
    logic        w_fault;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_fault(fetch_fault)
    );

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset_w),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .redirect_valid(w_rv), .redirect_pc(w_rpc),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
        .instr_ready(w_ready), .fetch_fault(w_fault)
    );

    // Garbage when no request was made, so unrequested writes show up.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;
        w_rdata    <= w_req ? (w_addr ^ K) : 32'hDEAD_BEEF;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] expq[$];
    logic [31:0] e;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL rst_req got %b want 0", imem_req);
        end
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_valid got %b want 0", instr_valid);
        end
        n_cmp++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_instr got %h/%h want 0/0", instr, instr_pc);
        end
        n_cmp++;
        if (fetch_fault !== 1'b0) begin
            n_bad++; $display("FAIL rst_fault got %b want 0", fetch_fault);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wq[$];
        logic [31:0] we;
        int          got;
        got = 0;
        wq = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        @(negedge clk);
        reset_w = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (w_valid && w_ready && wq.size() > 0) begin
                we = wq.pop_front();
                got++;
                n_cmp++;
                if (w_pc !== we || w_instr !== (we ^ K)) begin
                    n_bad++;
                    $display("FAIL wrap_pc got %h/%h want %h/%h",
                             w_pc, w_instr, we, we ^ K);
                end
            end
        end
        n_cmp++;
        if (got != 4) begin
            n_bad++; $display("FAIL wrap_count got %0d want 4", got);
        end
    endtask

    // Expects reset asserted on entry; releases it and checks start-up.
    task automatic test_stream();
        expq.delete();
        for (int i = 0; i < 64; i++)
            expq.push_back(32'(i * 4));
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL idle_req got %b want 0", imem_req);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL first_req got %b@%h want 1@0", imem_req, imem_addr);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL latency got valid=%b want 0", instr_valid);
        end
        repeat (12) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL stream_bubble got %b want 1", instr_valid);
            end
            if (instr_valid && instr_ready) begin
                e = expq.pop_front();
                n_cmp++;
                if (instr_pc !== e || instr !== (e ^ K)) begin
                    n_bad++;
                    $display("FAIL stream_pc got %h/%h want %h/%h",
                             instr_pc, instr, e, e ^ K);
                end
            end
        end
    endtask

    task automatic test_stall();
        repeat (5) begin
            @(negedge clk);
            instr_ready = 1'b0;
            #1;
            n_cmp++;
            if (instr_valid !== 1'b1 || instr_pc !== expq[0] ||
                instr !== (expq[0] ^ K)) begin
                n_bad++;
                $display("FAIL stall_head got %b %h/%h want 1 %h",
                         instr_valid, instr_pc, instr, expq[0]);
            end
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_bad++; $display("FAIL stall_req got %b want 0", imem_req);
            end
        end
        repeat (8) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #1;
            n_cmp++;
            if (instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL resume_bubble got %b want 1", instr_valid);
            end
            if (instr_valid && instr_ready) begin
                e = expq.pop_front();
                n_cmp++;
                if (instr_pc !== e || instr !== (e ^ K)) begin
                    n_bad++;
                    $display("FAIL resume_pc got %h/%h want %h", instr_pc, instr, e);
                end
            end
        end
    endtask

    task automatic test_redirect(input logic fill, input logic [31:0] tgt);
        if (fill) begin
            repeat (3) begin
                @(negedge clk);
                instr_ready = 1'b0;
            end
        end
        @(negedge clk);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== tgt) begin
            n_bad++;
            $display("FAIL redir_req got %b@%h want 1@%h", imem_req, imem_addr, tgt);
        end
        expq.delete();
        for (int i = 0; i < 16; i++)
            expq.push_back(tgt + 32'(i * 4));
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL redir_flush got valid=%b want 0", instr_valid);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL redir_bubble got %b want 1", instr_valid);
            end
            if (instr_valid && instr_ready) begin
                e = expq.pop_front();
                n_cmp++;
                if (instr_pc !== e || instr !== (e ^ K)) begin
                    n_bad++;
                    $display("FAIL redir_pc got %h/%h want %h", instr_pc, instr, e);
                end
            end
        end
    endtask

    task automatic test_fault();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL fault_req got %b want 0", imem_req);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (4) begin
            #1;
            n_cmp++;
            if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_state got f=%b v=%b r=%b want 1 0 0",
                         fetch_fault, instr_valid, imem_req);
            end
            @(negedge clk);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL resume_req got %b@%h want 1@200", imem_req, imem_addr);
        end
        expq.delete();
        for (int i = 0; i < 16; i++)
            expq.push_back(32'h200 + 32'(i * 4));
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL resume_lat got %b want 0", instr_valid);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (fetch_fault !== 1'b1) begin
                n_bad++; $display("FAIL fault_sticky got %b want 1", fetch_fault);
            end
            n_cmp++;
            if (instr_valid !== 1'b1) begin
                n_bad++; $display("FAIL resume_bubble2 got %b want 1", instr_valid);
            end
            if (instr_valid && instr_ready) begin
                e = expq.pop_front();
                n_cmp++;
                if (instr_pc !== e || instr !== (e ^ K)) begin
                    n_bad++;
                    $display("FAIL resume_pc2 got %h/%h want %h", instr_pc, instr, e);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_rst_out got %b %h/%h want 0 0/0",
                     instr_valid, instr, instr_pc);
        end
        n_cmp++;
        if (imem_req !== 1'b0 || fetch_fault !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_ctl got r=%b f=%b want 0 0", imem_req, fetch_fault);
        end
        repeat (2) @(negedge clk);
        test_stream();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stream();
        test_stall();
        test_redirect(1'b1, 32'h0000_0100);
        test_redirect(1'b0, 32'h0000_0040);
        test_fault();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
